// File: rtl/fast_pwm_ctrl.sv
// fast_pwm_ctrl: run-time config and duty-ramp controller for one Fast_PWM instance.
module fast_pwm_ctrl #(
  parameter int WIDTH = 32,
  parameter int STEP = 1,
  parameter int MIN_TOP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_top,
  input  logic [WIDTH-1:0] cfg_duty_a,
  input  logic [WIDTH-1:0] cfg_duty_b,
  output logic             cfg_err,
  output logic [WIDTH-1:0] timer_top,
  output logic [WIDTH-1:0] pwm_cnta,
  output logic [WIDTH-1:0] pwm_cntb,
  output logic             pwm_reset,
  output logic             period_end,
  output logic             busy
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_TOP);
  state_t state, state_nxt;
  logic [WIDTH-1:0] cnt, sh_top, sh_a, sh_b, tgt_a, tgt_b;
  logic [WIDTH-1:0] new_top, new_ta, new_tb, nxt_a, nxt_b;
  logic pending, xfer, load;
  // clamp to the (possibly new) top first, then move at most STEP toward target
  function automatic logic [WIDTH-1:0] ramp(input logic [WIDTH-1:0] cur, input logic [WIDTH-1:0] tgt,
                                            input logic [WIDTH-1:0] top);
    logic [WIDTH-1:0] c;
    c = cur > top ? top : cur;
    return c < tgt ? (tgt - c > STEP_W ? c + STEP_W : tgt) : (c - tgt > STEP_W ? c - STEP_W : tgt);
  endfunction
  assign cfg_ready = !pending;
  assign pwm_reset = state == IDLE;
  assign busy = pending | (pwm_cnta != tgt_a) | (pwm_cntb != tgt_b);
  always_comb begin
    xfer = cfg_valid && cfg_ready;
    load = state == IDLE && pending;
    period_end = state == RUN && cnt == timer_top;
    new_top = pending ? sh_top : timer_top;
    new_ta = pending ? sh_a : tgt_a;
    new_tb = pending ? sh_b : tgt_b;
    nxt_a = load ? sh_a : ramp(pwm_cnta, new_ta, new_top);
    nxt_b = load ? sh_b : ramp(pwm_cntb, new_tb, new_top);
    state_nxt = state == IDLE ? ((enable && timer_top >= MIN_W && !pending) ? RUN : IDLE)
                              : ((period_end && !enable) ? IDLE : RUN);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      sh_top <= '0;
      sh_a <= '0;
      sh_b <= '0;
      tgt_a <= '0;
      tgt_b <= '0;
      timer_top <= '0;
      pwm_cnta <= '0;
      pwm_cntb <= '0;
      pending <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= (state == RUN && !period_end) ? cnt + WIDTH'(1) : '0;
      cfg_err <= xfer && cfg_top < MIN_W;
      if (load || period_end) begin
        timer_top <= new_top;
        tgt_a <= new_ta;
        tgt_b <= new_tb;
        pwm_cnta <= nxt_a;
        pwm_cntb <= nxt_b;
        pending <= 1'b0;
      end
      if (xfer && cfg_top >= MIN_W) begin
        sh_top <= cfg_top;
        sh_a <= cfg_duty_a > cfg_top ? cfg_top : cfg_duty_a;
        sh_b <= cfg_duty_b > cfg_top ? cfg_top : cfg_duty_b;
        pending <= 1'b1;
      end
    end
  end
endmodule
